// File: rtl/rv32i_pkg.sv
// Shared RV32I core types: PC select encoding, fetch FSM states, fetch buffer entry.
package rv32i_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam int PCSEL_W = 1;
  typedef enum logic [PCSEL_W-1:0] {
    PC_4   = 1'b0,
    PC_ALU = 1'b1
  } PCSel_e;

  typedef enum logic [1:0] {
    F_BOOT = 2'd0,
    F_RUN  = 2'd1,
    F_HALT = 2'd2
  } FetchState_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/rv32i_fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries with a single-cycle flush.
module rv32i_fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic [AW:0]  count_o,
  output logic         empty_o,
  output logic         full_o
);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  fetch_entry_t  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is only taken when the head leaves the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage, pointers and occupancy; flush discards everything and ignores a same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/rv32i_fetch_stage.sv
// RV32I instruction fetch: owns the PC, credit-limited imem requests, in-order
// responses into a small buffer, redirect handling with stale-response dropping.
module rv32i_fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PCSEL_W-1:0] pc_sel_i,
  input  logic [31:0]        alu_target_i,
  output logic               imem_req_valid_o,
  input  logic               imem_req_ready_i,
  output logic [31:0]        imem_req_addr_o,
  input  logic               imem_rsp_valid_i,
  input  logic [31:0]        imem_rsp_data_i,
  output logic               id_valid_o,
  input  logic               id_ready_i,
  output logic [31:0]        id_instr_o,
  output logic [31:0]        id_pc_o,
  output logic [31:0]        id_pc4_o,
  output logic               fetch_err_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  FetchState_e   state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;

  logic          redirect, req_valid, req_fire, rsp_push, rsp_dec, pop;
  logic [31:0]   target;
  logic [CW:0]   reserved;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full;
  fetch_entry_t  fifo_head, fifo_wdata;

  // Bit 0 of the ALU sum is cleared (JALR semantics); bit 1 set means misaligned.
  assign target   = alu_target_i & ~32'h1;
  assign redirect = (state_q == F_RUN) && (pc_sel_i == PC_ALU);
  // Every in-flight request must have a guaranteed buffer slot waiting for it.
  assign reserved = {1'b0, out_q} + {1'b0, fifo_count};
  assign req_valid = (state_q == F_RUN) && !fifo_full && (reserved < (CW+1)'(FIFO_DEPTH));
  assign req_fire  = req_valid && imem_req_ready_i;
  assign rsp_dec   = imem_rsp_valid_i && (out_q != '0);
  assign rsp_push  = imem_rsp_valid_i && (drop_q == '0) && (state_q != F_HALT);
  // The head is not consumed on a redirect; the flush removes it anyway.
  assign pop       = !fifo_empty && id_ready_i && !redirect;
  assign fifo_wdata = '{instr: imem_rsp_data_i, pc: rsp_pc_q};

  // Next-state: FSM, PC, response PC, outstanding and drop accounting.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q + CW'(req_fire) - CW'(rsp_dec);
    drop_d   = drop_q;
    if (imem_rsp_valid_i && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (req_fire) pc_d = pc_q + 32'd4;
    if (rsp_push) rsp_pc_d = rsp_pc_q + 32'd4;
    unique case (state_q)
      F_BOOT: state_d = F_RUN;
      F_RUN: begin
        if (redirect) begin
          // Everything still in flight after this edge belongs to the old path.
          drop_d = out_d;
          if (target[1]) begin
            state_d = F_HALT;
          end else begin
            pc_d     = target;
            rsp_pc_d = target;
          end
        end
      end
      F_HALT:  state_d = F_HALT;
      default: state_d = F_BOOT;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= F_BOOT;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  rv32i_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rsp_push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = pc_q;
  assign id_valid_o       = !fifo_empty;
  // Decode fields read as zero while nothing is buffered.
  assign id_instr_o       = fifo_empty ? 32'h0 : fifo_head.instr;
  assign id_pc_o          = fifo_empty ? 32'h0 : fifo_head.pc;
  assign id_pc4_o         = fifo_empty ? 32'h0 : fifo_head.pc + 32'd4;
  assign fetch_err_o      = (state_q == F_HALT);

endmodule
